player_mover: RTL and testbench
===============================

// Module: player_mover
// PURPOSE
//  Downstream consumer of the rectangle obstacle stage. Takes button codes plus the
//  up/down/left/right enables (AND-reduced across all rectangles, outside this block).
//  Produces the player square's position and colour, which feed back into every
//  rectangle and into the pixel renderer.
//  Provides held-button auto-repeat, screen clamping and colour cycling.
// PARAMETERS
//  SCREEN_W     640  visible width, pixels
//  SCREEN_H     480  visible height, pixels
//  PLAYER_SIZE  12   player square edge, pixels
//  START_H      314  reset hPos
//  START_V      234  reset vPos
//  STEP_DIV     4    btnClk ticks per pixel while a direction is held (>=2)
//  NUM_COLORS   4    colour count; player_color cycles 0..NUM_COLORS-1
// PORTS
//  btnClk        in   1   single clock (movement tick)
//  rst           in   1   synchronous, active-high reset
//  btns          in   4   8=U 4=D 2=R 1=L; any other code = no direction
//  upEnable      in   1   1 = upward move permitted
//  downEnable    in   1   1 = downward move permitted
//  leftEnable    in   1   1 = leftward move permitted
//  rightEnable   in   1   1 = rightward move permitted
//  color_btn     in   1   level; each rising edge advances player colour
//  player_hPos   out  32  player left edge
//  player_vPos   out  32  player top edge
//  player_color  out  4   current colour index
//  moving        out  1   1 in the cycle a step was applied
//  blocked       out  1   1 when a step was due but was refused (enable low or at bound)
// BEHAVIOUR
//  Reset (sync, btnClk edge with rst=1): hPos=START_H, vPos=START_V, player_color=0,
//   moving=0, blocked=0, state=IDLE, div_cnt=0, btns_q=0, color_q=0.
//   rst wins over all other activity.
//  Input stage: btns and color_btn are registered (btns_q, color_q). dir = decode(btns_q).
//  Latency: a btns value present at edge n gives its first step at edge n+1,
//   i.e. visible on player_*Pos after edge n+1.
//  FSM with two states, IDLE and HOLD; held_dir is a register.
//   IDLE: dir valid -> "step attempt"; held_dir=dir; div_cnt=0; go to HOLD. Else stay.
//   HOLD: dir invalid -> IDLE, div_cnt=0, no step.
//    dir != held_dir (valid) -> immediate step attempt; held_dir=dir; div_cnt=0.
//    dir == held_dir -> div_cnt++; at div_cnt==STEP_DIV-1: step attempt, div_cnt=0.
//  Step attempt succeeds only when the matching enable=1 AND the in-bounds test passes:
//   U: vPos>0
//   D: vPos+PLAYER_SIZE<SCREEN_H
//   L: hPos>0
//   R: hPos+PLAYER_SIZE<SCREEN_W
//   Success: position changes by exactly 1 pixel; moving=1; blocked=0.
//   Failure: position unchanged; moving=0; blocked=1. Counter cadence is unaffected.
//   Clamp only; never wrap. Enables arrive registered upstream and are used as sampled.
//  moving/blocked are 0 in every cycle without a step attempt.
//  Colour: rising edge of color_q (color_q=1, previous value 0) ->
//   player_color = (player_color==NUM_COLORS-1) ? 0 : player_color+1.
//   This is independent of, and may coincide with, a move; both take effect in the same cycle.
//  All position arithmetic is 32-bit unsigned. Compare using additions only (no subtraction),
//   so underflow is impossible.
// STRUCTURE
//  Shared package: DIR_U=4'd8, DIR_D=4'd4, DIR_R=4'd2, DIR_L=4'd1, DIR_NONE;
//   FSM state encoding (IDLE, HOLD); SCREEN_W/SCREEN_H/PLAYER_SIZE defaults,
//   also used by the rectangle stage.
//  One sub-module: rise_detect (1-bit registered rising-edge pulse, sync reset),
//   used for color_btn.
//  Direction decode, step counter and bound checks stay inline.
// TESTING
//  1. Reset -> (314,234), colour 0, moving=0, blocked=0.
//   btns=2 held 9 edges, all enables 1 -> steps at edges 2,6,10 -> hPos=317.
//  2. vPos forced to 0 via START_V=0, btns=8 -> blocked=1 every step slot, vPos stays 0.
//   Likewise START_H=628, btns=2 -> hPos stays 628.
//  3. btns=4 with downEnable=0 -> no vPos change, blocked=1.
//   downEnable->1 mid-hold -> next slot steps, vPos+1.
//  4. btns 2 -> 1 switch while in HOLD -> immediate left step the next edge, counter restarts.
//   btns=4'hA -> no motion, FSM returns to IDLE.
//  5. Five color_btn pulses with NUM_COLORS=4 -> colour 1,2,3,0,1.
//   Colour pulse coincident with a step -> both applied in the same cycle.
//  6. rst=1 asserted mid-HOLD after 3 steps -> the next edge restores the START position,
//   colour 0 and IDLE; no step occurs on that edge.

Source files
------------

// File: rtl/player_mover_pkg.sv
// Shared constants for the player mover and the rectangle obstacle stage:
// button direction codes, FSM state encoding and default screen geometry.
package player_mover_pkg;

  localparam int unsigned SCREEN_W_DEF    = 640;
  localparam int unsigned SCREEN_H_DEF    = 480;
  localparam int unsigned PLAYER_SIZE_DEF = 12;

  localparam int unsigned POS_W   = 32;
  localparam int unsigned BTN_W   = 4;
  localparam int unsigned COLOR_W = 4;

  localparam logic [BTN_W-1:0] DIR_U    = 4'd8;
  localparam logic [BTN_W-1:0] DIR_D    = 4'd4;
  localparam logic [BTN_W-1:0] DIR_R    = 4'd2;
  localparam logic [BTN_W-1:0] DIR_L    = 4'd1;
  localparam logic [BTN_W-1:0] DIR_NONE = 4'd0;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  // Map a raw button code onto a direction; anything but a single known code is no direction.
  function automatic logic [BTN_W-1:0] decode_dir(input logic [BTN_W-1:0] code);
    case (code)
      DIR_U, DIR_D, DIR_R, DIR_L: decode_dir = code;
      default:                    decode_dir = DIR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/player_mover_rise_detect.sv
// Registers a level input and emits a one-cycle registered pulse on its rising edge.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);

  logic q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q     <= 1'b0;
      pulse <= 1'b0;
    end else begin
      q     <= d;
      pulse <= d & ~q;
    end
  end

endmodule

// File: rtl/player_mover.sv
// Player square position/colour: held-button auto-repeat, clamped stepping
// gated by obstacle enables, and colour cycling on a separate button.
module player_mover
  import player_mover_pkg::*;
#(
  parameter int unsigned SCREEN_W    = SCREEN_W_DEF,
  parameter int unsigned SCREEN_H    = SCREEN_H_DEF,
  parameter int unsigned PLAYER_SIZE = PLAYER_SIZE_DEF,
  parameter int unsigned START_H     = 314,
  parameter int unsigned START_V     = 234,
  parameter int unsigned STEP_DIV    = 4,
  parameter int unsigned NUM_COLORS  = 4
) (
  input  logic                 btnClk,
  input  logic                 rst,
  input  logic [BTN_W-1:0]     btns,
  input  logic                 upEnable,
  input  logic                 downEnable,
  input  logic                 leftEnable,
  input  logic                 rightEnable,
  input  logic                 color_btn,
  output logic [POS_W-1:0]     player_hPos,
  output logic [POS_W-1:0]     player_vPos,
  output logic [COLOR_W-1:0]   player_color,
  output logic                 moving,
  output logic                 blocked
);

  localparam int unsigned CNT_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;

  logic [BTN_W-1:0] btns_q;
  logic [BTN_W-1:0] dir;
  logic [BTN_W-1:0] held_dir, held_dir_n;
  logic [0:0]       state, state_n;
  logic [CNT_W-1:0] div_cnt, div_cnt_n;
  logic             attempt;
  logic             step_ok;
  logic             color_rise;
  logic [POS_W-1:0] h_next, v_next;
  logic [COLOR_W-1:0] color_next;

  rise_detect u_color_rise (
    .clk   (btnClk),
    .rst   (rst),
    .d     (color_btn),
    .pulse (color_rise)
  );

  assign dir = decode_dir(btns_q);

  // Auto-repeat FSM: first step immediately, then one step every STEP_DIV ticks.
  always_comb begin
    state_n    = state;
    held_dir_n = held_dir;
    div_cnt_n  = div_cnt;
    attempt    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (dir != DIR_NONE) begin
          attempt    = 1'b1;
          held_dir_n = dir;
          div_cnt_n  = '0;
          state_n    = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (dir == DIR_NONE) begin
          state_n   = ST_IDLE;
          div_cnt_n = '0;
        end else if (dir != held_dir) begin
          attempt    = 1'b1;
          held_dir_n = dir;
          div_cnt_n  = '0;
        end else if (div_cnt == CNT_W'(STEP_DIV - 1)) begin
          attempt   = 1'b1;
          div_cnt_n = '0;
        end else begin
          div_cnt_n = div_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n   = ST_IDLE;
        div_cnt_n = '0;
      end
    endcase
  end

  // Bound checks use additions only so the unsigned position can never underflow.
  always_comb begin
    step_ok = 1'b0;
    h_next  = player_hPos;
    v_next  = player_vPos;
    case (dir)
      DIR_U: begin
        step_ok = upEnable && (player_vPos > POS_W'(0));
        v_next  = player_vPos - POS_W'(1);
      end
      DIR_D: begin
        step_ok = downEnable && ((player_vPos + POS_W'(PLAYER_SIZE)) < POS_W'(SCREEN_H));
        v_next  = player_vPos + POS_W'(1);
      end
      DIR_L: begin
        step_ok = leftEnable && (player_hPos > POS_W'(0));
        h_next  = player_hPos - POS_W'(1);
      end
      DIR_R: begin
        step_ok = rightEnable && ((player_hPos + POS_W'(PLAYER_SIZE)) < POS_W'(SCREEN_W));
        h_next  = player_hPos + POS_W'(1);
      end
      default: step_ok = 1'b0;
    endcase
  end

  always_comb begin
    color_next = player_color;
    if (color_rise) begin
      color_next = (player_color == COLOR_W'(NUM_COLORS - 1)) ? '0 : player_color + COLOR_W'(1);
    end
  end

  always_ff @(posedge btnClk) begin
    if (rst) begin
      btns_q       <= DIR_NONE;
      state        <= ST_IDLE;
      held_dir     <= DIR_NONE;
      div_cnt      <= '0;
      player_hPos  <= POS_W'(START_H);
      player_vPos  <= POS_W'(START_V);
      player_color <= '0;
      moving       <= 1'b0;
      blocked      <= 1'b0;
    end else begin
      btns_q       <= btns;
      state        <= state_n;
      held_dir     <= held_dir_n;
      div_cnt      <= div_cnt_n;
      player_color <= color_next;
      moving       <= attempt && step_ok;
      blocked      <= attempt && !step_ok;
      if (attempt && step_ok) begin
        player_hPos <= h_next;
        player_vPos <= v_next;
      end
    end
  end

endmodule

// File: tb/tb_player_mover.sv
// Bench for player_mover: two instances (centre start and corner start) share stimulus
// and are checked every cycle against a run-length based reference model.
module tb_player_mover;

  localparam int unsigned STEP_DIV   = 4;
  localparam int unsigned NUM_COLORS = 4;
  localparam int unsigned SW = 640, SH = 480, PS = 12;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] btns;
  logic en_u, en_d, en_l, en_r;
  logic color_btn;

  logic [31:0] h0, v0, h1, v1;
  logic [3:0]  c0, c1;
  logic        mv0, bk0, mv1, bk1;

  always #5 clk = ~clk;

  player_mover u0 (
    .btnClk(clk), .rst(rst), .btns(btns),
    .upEnable(en_u), .downEnable(en_d), .leftEnable(en_l), .rightEnable(en_r),
    .color_btn(color_btn),
    .player_hPos(h0), .player_vPos(v0), .player_color(c0),
    .moving(mv0), .blocked(bk0)
  );

  player_mover #(.START_H(628), .START_V(0)) u1 (
    .btnClk(clk), .rst(rst), .btns(btns),
    .upEnable(en_u), .downEnable(en_d), .leftEnable(en_l), .rightEnable(en_r),
    .color_btn(color_btn),
    .player_hPos(h1), .player_vPos(v1), .player_color(c1),
    .moving(mv1), .blocked(bk1)
  );

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 0;

  task automatic check(input string nm, input longint unsigned act, input longint unsigned exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a step is due on the 1st, (1+STEP_DIV)th, ... consecutive
  // cycle in which the same valid direction is seen (one cycle after the button).
  int unsigned start_h [2] = '{314, 628};
  int unsigned start_v [2] = '{234, 0};
  longint unsigned m_h [2];
  longint unsigned m_v [2];
  bit m_mov [2];
  bit m_blk [2];
  int unsigned m_col;
  logic [3:0] seen_btns;
  logic [3:0] run_dir;
  int unsigned run_len;
  bit col_d1, col_d2;

  function automatic bit is_dir(input logic [3:0] b);
    return (b == 4'd8) || (b == 4'd4) || (b == 4'd2) || (b == 4'd1);
  endfunction

  always @(posedge clk) begin
    logic [3:0] d;
    bit due, ok;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_h[i] = start_h[i];
        m_v[i] = start_v[i];
        m_mov[i] = 0;
        m_blk[i] = 0;
      end
      m_col = 0;
      seen_btns = 4'd0;
      run_dir = 4'd0;
      run_len = 0;
      col_d1 = 0;
      col_d2 = 0;
    end else begin
      d = is_dir(seen_btns) ? seen_btns : 4'd0;
      if (d != 4'd0) begin
        if (run_len > 0 && d == run_dir) run_len++;
        else run_len = 1;
        run_dir = d;
      end else begin
        run_len = 0;
      end
      due = (d != 4'd0) && (((run_len - 1) % STEP_DIV) == 0);
      for (int i = 0; i < 2; i++) begin
        ok = 0;
        if (due) begin
          case (d)
            4'd8: ok = en_u && (m_v[i] >= 1);
            4'd4: ok = en_d && (m_v[i] + PS < SH);
            4'd1: ok = en_l && (m_h[i] >= 1);
            4'd2: ok = en_r && (m_h[i] + PS < SW);
            default: ok = 0;
          endcase
          if (ok) begin
            if (d == 4'd8) m_v[i] = m_v[i] - 1;
            if (d == 4'd4) m_v[i] = m_v[i] + 1;
            if (d == 4'd1) m_h[i] = m_h[i] - 1;
            if (d == 4'd2) m_h[i] = m_h[i] + 1;
          end
        end
        m_mov[i] = due && ok;
        m_blk[i] = due && !ok;
      end
      if (col_d1 && !col_d2) m_col = (m_col + 1) % NUM_COLORS;
      col_d2 = col_d1;
      col_d1 = color_btn;
      seen_btns = btns;
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("hpos0", h0, m_h[0]);
      check("vpos0", v0, m_v[0]);
      check("color0", c0, m_col);
      check("moving0", mv0, m_mov[0]);
      check("blocked0", bk0, m_blk[0]);
      check("hpos1", h1, m_h[1]);
      check("vpos1", v1, m_v[1]);
      check("color1", c1, m_col);
      check("moving1", mv1, m_mov[1]);
      check("blocked1", bk1, m_blk[1]);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  int exp_col [5] = '{1, 2, 3, 0, 1};
  int sel;

  initial begin
    rst = 1'b1; btns = 4'd0; color_btn = 1'b0;
    en_u = 1'b1; en_d = 1'b1; en_l = 1'b1; en_r = 1'b1;
    tick(1);
    chk_en = 1;
    tick(1);
    check("rst_hpos", h0, 314);
    check("rst_vpos", v0, 234);
    check("rst_color", c0, 0);
    check("rst_moving", mv0, 0);
    check("rst_blocked", bk0, 0);

    // Held right: steps at edges 2, 6, 10
    rst = 1'b0; btns = 4'd2;
    tick(2);
    check("first_step_h", h0, 315);
    check("first_step_mv", mv0, 1);
    tick(8);
    check("held_right_h", h0, 317);
    check("right_edge_h", h1, 628);
    check("right_edge_blk", bk1, 1);

    // Up at the top edge
    btns = 4'd8;
    tick(2);
    check("up_v0", v0, 233);
    check("top_edge_v", v1, 0);
    check("top_edge_blk", bk1, 1);

    // Down refused, then permitted mid-hold
    btns = 4'd0; tick(2);
    en_d = 1'b0; btns = 4'd4;
    tick(2);
    check("down_refused_blk", bk0, 1);
    check("down_refused_v", v0, 233);
    en_d = 1'b1;
    tick(4);
    check("down_later_v", v0, 234);
    check("down_later_mv", mv0, 1);

    // Direction switches restart the cadence
    btns = 4'd2; tick(2);
    check("switch_r_h", h0, 318);
    btns = 4'd1; tick(2);
    check("switch_l_h", h0, 317);
    check("switch_l_mv", mv0, 1);
    btns = 4'hA; tick(2);
    check("invalid_mv", mv0, 0);
    check("invalid_blk", bk0, 0);

    // Colour cycling
    for (int i = 0; i < 5; i++) begin
      color_btn = 1'b1; tick(1);
      color_btn = 1'b0; tick(1);
      check("color_cycle", c0, exp_col[i]);
    end
    btns = 4'd0; tick(2);
    btns = 4'd2; color_btn = 1'b1; tick(1);
    color_btn = 1'b0; tick(1);
    check("coincide_color", c0, 2);
    check("coincide_h", h0, 318);
    check("coincide_mv", mv0, 1);

    // Reset mid-hold after further steps
    tick(8);
    check("pre_reset_h", h0, 320);
    rst = 1'b1; tick(1);
    check("mid_rst_h", h0, 314);
    check("mid_rst_v", v0, 234);
    check("mid_rst_color", c0, 0);
    check("mid_rst_mv", mv0, 0);
    rst = 1'b0;

    // Randomized phase
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if ($urandom_range(0, 7) == 0) begin
        sel = $urandom_range(0, 6);
        case (sel)
          0: btns = 4'd0;
          1: btns = 4'd1;
          2: btns = 4'd2;
          3: btns = 4'd4;
          4: btns = 4'd8;
          5: btns = 4'hA;
          default: btns = 4'($urandom_range(0, 15));
        endcase
      end
      en_u = ($urandom_range(0, 9) != 0);
      en_d = ($urandom_range(0, 9) != 0);
      en_l = ($urandom_range(0, 9) != 0);
      en_r = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 5) == 0) color_btn = ~color_btn;
      rst = ($urandom_range(0, 599) == 0);
      tick(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
